ecc_enc_dec: RTL and testbench

APB-programmable SECDED (extended Hamming) engine. Software loads data, codeword width and a noise mask over APB, then writes the control register to start an encode, a decode or a full channel run (encode, inject noise, decode). The result appears on dedicated output ports with a one-cycle done strobe. The block is a peripheral slave on the APB bus.

---
 rtl/ecc_enc_dec.sv | 169 ++++++++++++++++
 tb/tb_ecc_enc_dec.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ecc_enc_dec.sv
// APB-programmable SECDED (extended Hamming) engine: encode, decode or full channel
// (encode, add noise, decode) on 8/16/32-bit codewords, result one clock after the CTRL write.
`timescale 1ns/1ps
module ecc_enc_dec #(
    parameter int DATA_WIDTH      = 32,
    parameter int AMBA_ADDR_WIDTH = 20,
    parameter int AMBA_WORD       = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [AMBA_ADDR_WIDTH-1:0] PADDR,
    input  logic                       PENABLE,
    input  logic                       PSEL,
    input  logic [AMBA_WORD-1:0]       PWDATA,
    input  logic                       PWRITE,
    output logic [AMBA_WORD-1:0]       PRDATA,
    output logic [DATA_WIDTH-1:0]      data_out,
    output logic                       operation_done,
    output logic [1:0]                 num_of_errors
);
    localparam int CW = 32;
    localparam logic [AMBA_ADDR_WIDTH-1:0] A_CTRL  = AMBA_ADDR_WIDTH'(32'h0);
    localparam logic [AMBA_ADDR_WIDTH-1:0] A_DATA  = AMBA_ADDR_WIDTH'(32'h4);
    localparam logic [AMBA_ADDR_WIDTH-1:0] A_WIDTH = AMBA_ADDR_WIDTH'(32'h8);
    localparam logic [AMBA_ADDR_WIDTH-1:0] A_NOISE = AMBA_ADDR_WIDTH'(32'hC);

    logic [1:0]            r_ctrl;
    logic [DATA_WIDTH-1:0] r_data;
    logic [1:0]            r_width;
    logic [DATA_WIDTH-1:0] r_noise;
    logic                  r_go;

    logic                  w_wr;
    logic                  w_start;
    int                    w_n;
    logic [CW-1:0]         w_nmask;
    logic [CW-1:0]         w_din;
    logic [CW-1:0]         w_noise;
    logic [CW-1:0]         w_cw;
    logic [CW-1:0]         w_rx;
    logic [CW-1:0]         w_fix;
    logic [CW-1:0]         w_ext;
    logic [CW-1:0]         w_res;
    logic [4:0]            w_syn;
    logic                  w_q;
    logic [1:0]            w_nerr;

    function automatic logic is_pow2(input int p);
        return (p & (p - 1)) == 0;
    endfunction

    assign w_wr    = PSEL & PENABLE & PWRITE;
    assign w_start = w_wr && (PADDR == A_CTRL) && (PWDATA[1:0] != 2'd3);
    assign w_din   = CW'(r_data);
    assign w_noise = CW'(r_noise);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ctrl  <= '0;
            r_data  <= '0;
            r_width <= '0;
            r_noise <= '0;
            r_go    <= 1'b0;
        end else begin
            r_go <= w_start;
            if (w_wr) begin
                case (PADDR)
                    A_CTRL:  r_ctrl  <= PWDATA[1:0];
                    A_DATA:  r_data  <= DATA_WIDTH'(PWDATA);
                    A_WIDTH: r_width <= PWDATA[1:0];
                    A_NOISE: r_noise <= DATA_WIDTH'(PWDATA);
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        PRDATA = '0;
        if (PSEL && !PWRITE) begin
            case (PADDR)
                A_CTRL:  PRDATA = AMBA_WORD'(r_ctrl);
                A_DATA:  PRDATA = AMBA_WORD'(r_data);
                A_WIDTH: PRDATA = AMBA_WORD'(r_width);
                A_NOISE: PRDATA = AMBA_WORD'(r_noise);
                default: PRDATA = '0;
            endcase
        end
    end

    always_comb begin
        case (r_width)
            2'd0:    begin w_n = 8;  w_nmask = 32'h0000_00FF; end
            2'd1:    begin w_n = 16; w_nmask = 32'h0000_FFFF; end
            default: begin w_n = 32; w_nmask = 32'hFFFF_FFFF; end
        endcase
    end

    // Encoder: scatter data into non-power-of-two slots, then fill parity slots.
    always_comb begin : enc
        int         idx;
        logic [4:0] par;
        w_cw = '0;
        idx  = 0;
        par  = '0;
        for (int p = 1; p < CW; p++) begin
            if (p < w_n && !is_pow2(p)) begin
                w_cw[p] = w_din[idx];
                idx++;
            end
        end
        for (int j = 0; j < 5; j++) begin
            for (int p = 1; p < CW; p++) begin
                if (p < w_n && p[j] && !is_pow2(p))
                    par[j] = par[j] ^ w_cw[p];
            end
        end
        for (int j = 0; j < 5; j++) begin
            if ((1 << j) < w_n)
                w_cw[1 << j] = par[j];
        end
        w_cw[0] = ^w_cw[CW-1:1];
    end

    // Decoder: syndrome plus overall parity classify 0/1/2 errors.
    always_comb begin : dec
        int idx;
        w_rx  = ((r_ctrl == 2'd2) ? (w_cw ^ w_noise) : w_din) & w_nmask;
        w_syn = '0;
        for (int p = 1; p < CW; p++) begin
            if (w_rx[p])
                w_syn = w_syn ^ 5'(p);
        end
        w_q   = ^w_rx;
        w_fix = w_rx;
        if (w_q)
            w_fix[w_syn] = ~w_rx[w_syn];
        w_ext = '0;
        idx   = 0;
        for (int p = 1; p < CW; p++) begin
            if (p < w_n && !is_pow2(p)) begin
                w_ext[idx] = w_fix[p];
                idx++;
            end
        end
        if (w_q)
            w_nerr = 2'd1;
        else if (w_syn != 5'd0)
            w_nerr = 2'd2;
        else
            w_nerr = 2'd0;
    end

    assign w_res = (r_ctrl == 2'd0) ? w_cw : w_ext;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out       <= '0;
            num_of_errors  <= 2'd0;
            operation_done <= 1'b0;
        end else begin
            operation_done <= r_go;
            if (r_go) begin
                data_out      <= DATA_WIDTH'(w_res);
                num_of_errors <= (r_ctrl == 2'd0) ? 2'd0 : w_nerr;
            end
        end
    end
endmodule

// File: tb/tb_ecc_enc_dec.sv
// Self-checking bench for ecc_enc_dec: directed cases plus randomized traffic
// against a brute-force nearest-codeword reference model.
`timescale 1ns/1ps
module tb_ecc_enc_dec;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [19:0] PADDR = '0;
    logic        PENABLE = 1'b0;
    logic        PSEL = 1'b0;
    logic [31:0] PWDATA = '0;
    logic        PWRITE = 1'b0;
    logic [31:0] PRDATA;
    logic [31:0] data_out;
    logic        operation_done;
    logic [1:0]  num_of_errors;

    int n_tests = 0;
    int n_fail  = 0;

    ecc_enc_dec dut (
        .clk(clk), .rst(rst), .PADDR(PADDR), .PENABLE(PENABLE), .PSEL(PSEL),
        .PWDATA(PWDATA), .PWRITE(PWRITE), .PRDATA(PRDATA), .data_out(data_out),
        .operation_done(operation_done), .num_of_errors(num_of_errors)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int nb(input logic [1:0] w);
        return (w == 2'd0) ? 8 : (w == 2'd1) ? 16 : 32;
    endfunction

    // Parity slots are chosen so the syndrome of the finished word is zero.
    function automatic logic [31:0] m_enc(input logic [31:0] d, input int n);
        logic [31:0] c;
        logic [4:0]  s;
        int          k;
        c = '0; s = '0; k = 0;
        for (int p = 1; p < n; p++)
            if ((p & (p - 1)) != 0) begin
                c[p] = d[k];
                k++;
            end
        for (int p = 1; p < n; p++)
            if (c[p]) s = s ^ 5'(p);
        for (int j = 0; j < 5; j++)
            if ((1 << j) < n) c[1 << j] = s[j];
        c[0] = ^c;
        return c;
    endfunction

    function automatic logic [31:0] m_ext(input logic [31:0] r, input int n);
        logic [31:0] d;
        int          k;
        d = '0; k = 0;
        for (int p = 1; p < n; p++)
            if ((p & (p - 1)) != 0) begin
                d[k] = r[p];
                k++;
            end
        return d;
    endfunction

    function automatic logic is_cw(input logic [31:0] r, input int n);
        return m_enc(m_ext(r, n), n) == r;
    endfunction

    // Classify by distance to the code: 0 if a codeword, 1 if one flip away, else 2.
    task automatic m_dec(input logic [31:0] r, input int n, output logic [31:0] d, output logic [1:0] e);
        logic [31:0] t;
        d = m_ext(r, n);
        e = 2'd2;
        if (is_cw(r, n)) e = 2'd0;
        else
            for (int i = 0; i < n; i++) begin
                t = r ^ (32'd1 << i);
                if (is_cw(t, n)) begin
                    e = 2'd1;
                    d = m_ext(t, n);
                end
            end
    endtask

    task automatic model(input logic [1:0] op, input logic [1:0] w, input logic [31:0] din,
                         input logic [31:0] noise, output logic [31:0] d, output logic [1:0] e);
        int          n;
        logic [31:0] msk;
        n   = nb(w);
        msk = (n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
        if (op == 2'd0) begin
            d = m_enc(din, n);
            e = 2'd0;
        end else
            m_dec(((op == 2'd2) ? (m_enc(din, n) ^ noise) : din) & msk, n, d, e);
    endtask

    // All bus tasks start and end 1 time unit after a rising edge.
    task automatic apb_wr(input logic [19:0] a, input logic [31:0] d);
        PSEL = 1'b1; PWRITE = 1'b1; PADDR = a; PWDATA = d; PENABLE = 1'b0;
        @(posedge clk); #1 PENABLE = 1'b1;
        @(posedge clk); #1 PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_rd(input logic [19:0] a, output logic [31:0] d);
        PSEL = 1'b1; PWRITE = 1'b0; PADDR = a; PENABLE = 1'b0;
        @(posedge clk); #1 PENABLE = 1'b1;
        #1 d = PRDATA;
        @(posedge clk); #1 PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] exp_d,
                          input logic [1:0] exp_e);
        apb_wr(20'h0, {30'd0, op});
        chk({tag, ".done_E0"}, {31'd0, operation_done}, 32'd0);
        @(posedge clk); #1;
        chk({tag, ".done_E1"}, {31'd0, operation_done}, 32'd1);
        chk({tag, ".data"}, data_out, exp_d);
        chk({tag, ".errs"}, {30'd0, num_of_errors}, {30'd0, exp_e});
        @(posedge clk); #1;
        chk({tag, ".done_E2"}, {31'd0, operation_done}, 32'd0);
    endtask

    initial begin
        logic [31:0] rd, cw, ed, nz, dv, keep_d;
        logic [1:0]  ee, op, w;
        int          nbit;

        repeat (2) @(posedge clk);
        #1;
        chk("rst.data", data_out, 32'd0);
        chk("rst.errs", {30'd0, num_of_errors}, 32'd0);
        chk("rst.done", {31'd0, operation_done}, 32'd0);
        for (int a = 0; a < 4; a++) begin
            apb_rd(20'(a * 4), rd);
            chk("rst.reg", rd, 32'd0);
        end
        rst = 1'b1;
        @(posedge clk); #1;

        apb_wr(20'h8, 32'd0);
        apb_wr(20'h4, 32'hE);
        run_op("enc8", 2'd0, 32'h0000_00F0, 2'd0);

        apb_wr(20'hC, 32'h20);
        apb_wr(20'h8, 32'd1);
        apb_wr(20'h4, 32'hE);
        run_op("chan16", 2'd2, 32'hE, 2'd1);

        apb_wr(20'h4, 32'h00F0 ^ 32'h0003);
        run_op("dec16_dbl", 2'd1, 32'hE, 2'd2);

        apb_wr(20'h8, 32'd2);
        apb_wr(20'h4, 32'h03FF_FFFF);
        cw = m_enc(32'h03FF_FFFF, 32);
        run_op("enc32", 2'd0, cw, 2'd0);
        apb_wr(20'h4, cw ^ 32'd1);
        run_op("dec32_c0", 2'd1, 32'h03FF_FFFF, 2'd1);

        // Reserved op: no pulse, outputs hold.
        keep_d = data_out;
        apb_wr(20'h0, 32'd3);
        chk("ctrl3.done0", {31'd0, operation_done}, 32'd0);
        @(posedge clk); #1;
        chk("ctrl3.done1", {31'd0, operation_done}, 32'd0);
        chk("ctrl3.data", data_out, keep_d);
        chk("ctrl3.errs", {30'd0, num_of_errors}, 32'd1);

        apb_wr(20'h4, 32'hDEAD_BEEF);
        apb_wr(20'h8, 32'hFFFF_FFF6);
        apb_wr(20'hC, 32'h1234_5678);
        apb_wr(20'h10, 32'hFFFF_FFFF);
        apb_wr(20'h1_0004, 32'h0);
        apb_rd(20'h0, rd);     chk("rb.ctrl", rd, 32'd3);
        apb_rd(20'h4, rd);     chk("rb.data", rd, 32'hDEAD_BEEF);
        apb_rd(20'h8, rd);     chk("rb.width", rd, 32'd2);
        apb_rd(20'hC, rd);     chk("rb.noise", rd, 32'h1234_5678);
        apb_rd(20'h10, rd);    chk("rb.unmapped", rd, 32'd0);
        apb_rd(20'h1_0004, rd); chk("rb.alias", rd, 32'd0);

        for (int it = 0; it < 80; it++) begin
            op   = 2'($urandom_range(0, 2));
            w    = 2'($urandom_range(0, 3));
            dv   = $urandom;
            nbit = nb(w);
            case ($urandom_range(0, 3))
                0: nz = 32'd0;
                1: nz = 32'd1 << $urandom_range(0, nbit - 1);
                2: nz = (32'd1 << $urandom_range(0, nbit - 1)) ^ (32'd1 << $urandom_range(0, nbit - 1));
                default: nz = $urandom;
            endcase
            if (op == 2'd1 && $urandom_range(0, 1) == 1)
                dv = m_enc(dv, nbit) ^ nz;
            apb_wr(20'hC, nz);
            apb_wr(20'h8, {30'd0, w});
            apb_wr(20'h4, dv);
            model(op, w, dv, nz, ed, ee);
            run_op($sformatf("rnd%0d", it), op, ed, ee);
        end

        // Reset during an operation cancels it.
        apb_wr(20'h0, 32'd0);
        rst = 1'b0;
        #1;
        chk("midrst.data", data_out, 32'd0);
        chk("midrst.errs", {30'd0, num_of_errors}, 32'd0);
        @(posedge clk); #1;
        chk("midrst.done", {31'd0, operation_done}, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst.done2", {31'd0, operation_done}, 32'd0);
        apb_rd(20'h4, rd);
        chk("midrst.reg", rd, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
